// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM word address and registers the
// fetched word into IF/ID. Handles stall, redirect with flush, and a sticky halt on bad fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_RANGE    = 2'b10;
  // 33 bits so a ROM covering the full 4 GiB space still yields a sane limit
  localparam logic [32:0] PC_LIMIT       = 33'(ROM_WORDS) * 33'd4;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        vld_n;
  logic [31:0] ipc_n, inst_n, cnt_n;
  logic        fault_n;
  logic [1:0]  cause_n;

  assign rom_addr = {2'b00, pc[31:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= '0;
      fetch_fault <= 1'b0;
      fault_cause <= 2'b00;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_valid <= vld_n;
      if_id_pc    <= ipc_n;
      if_id_inst  <= inst_n;
      fetch_fault <= fault_n;
      fault_cause <= cause_n;
      fetch_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    vld_n   = if_id_valid;
    ipc_n   = if_id_pc;
    inst_n  = if_id_inst;
    fault_n = fetch_fault;
    cause_n = fault_cause;
    cnt_n   = fetch_count;
    case (state)
      RUN: begin
        if (redirect) begin
          vld_n = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_n = HALT;
            fault_n = 1'b1;
            cause_n = CAUSE_MISALIGN;
          end else begin
            pc_n = redirect_pc;
          end
        end else if ({1'b0, pc} >= PC_LIMIT) begin
          // range check wins over stall so a stalled bad PC still halts
          state_n = HALT;
          fault_n = 1'b1;
          cause_n = CAUSE_RANGE;
          vld_n   = 1'b0;
        end else if (!stall) begin
          inst_n = rom_inst;
          ipc_n  = pc;
          vld_n  = 1'b1;
          pc_n   = pc + 32'd4;
          cnt_n  = fetch_count + 32'd1;
        end
      end
      HALT: vld_n = 1'b0;
      default: begin
        state_n = HALT;
        vld_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: drives a behavioural ROM and checks IF/ID, PC and
// fault behaviour against hand-computed values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, rom_addr, rom_inst;
  logic        if_id_valid, fetch_fault;
  logic [31:0] if_id_pc, if_id_inst, fetch_count;
  logic [1:0]  fault_cause;

  logic [31:0] rom [0:1023];
  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0), .ROM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .fetch_fault(fetch_fault),
    .fault_cause(fault_cause), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign rom_inst = (rom_addr < 32'd1024) ? rom[rom_addr[9:0]] : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] i, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, "_pc"},    if_id_pc,    p);
    chk({tag, "_inst"},  if_id_inst,  i);
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  task automatic chk_reset(input string tag);
    chk_ifid(tag, 1'b0, 32'h0, 32'h0, 32'h0);
    chk({tag, "_fault"},   {31'd0, fetch_fault}, 32'h0);
    chk({tag, "_cause"},   {30'd0, fault_cause}, 32'h0);
    chk({tag, "_romaddr"}, rom_addr, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h1111_1111; rom[1] = 32'h2222_2222;
    rom[2] = 32'h3333_3333; rom[3] = 32'h4444_4444;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    step();
    chk_reset("reset");
    rst = 1'b0;

    // Sequential fetch with a 3-cycle stall at pc=8
    step(); chk_ifid("adv0", 1'b1, 32'h0, 32'h1111_1111, 32'd1);
    step(); chk_ifid("adv1", 1'b1, 32'h4, 32'h2222_2222, 32'd2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("stall", 1'b1, 32'h4, 32'h2222_2222, 32'd2);
      chk("stall_romaddr", rom_addr, 32'h2);
    end
    stall = 1'b0;
    step(); chk_ifid("adv2", 1'b1, 32'h8, 32'h3333_3333, 32'd3);
    step(); chk_ifid("adv3", 1'b1, 32'hC, 32'h4444_4444, 32'd4);
    chk("adv3_romaddr", rom_addr, 32'h4);

    // Redirect with stall in the same cycle: flush, then fetch target
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    chk_ifid("redir", 1'b0, 32'hC, 32'h4444_4444, 32'd4);
    chk("redir_romaddr", rom_addr, 32'h10);
    redirect = 1'b0; stall = 1'b0;
    step(); chk_ifid("redir_tgt", 1'b1, 32'h40, 32'hA000_0010, 32'd5);

    // Misaligned redirect halts; later redirect ignored
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    chk("mis_fault", {31'd0, fetch_fault}, 32'h1);
    chk("mis_cause", {30'd0, fault_cause}, 32'h1);
    chk("mis_valid", {31'd0, if_id_valid}, 32'h0);
    chk("mis_romaddr", rom_addr, 32'h11);
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step();
    chk("halt_romaddr", rom_addr, 32'h11);
    chk("halt_valid", {31'd0, if_id_valid}, 32'h0);
    chk("halt_cause", {30'd0, fault_cause}, 32'h1);
    chk("halt_count", fetch_count, 32'd5);

    // Reset wins over a simultaneous redirect
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    chk_reset("rst2");
    rst = 1'b0; redirect = 1'b0;

    // Walk the whole ROM; last word fetches, next edge faults even under stall
    for (int k = 0; k < 1024; k++) step();
    chk_ifid("last", 1'b1, 32'hFFC, 32'hA000_03FF, 32'd1024);
    chk("last_romaddr", rom_addr, 32'h400);
    stall = 1'b1;
    step();
    chk("range_fault", {31'd0, fetch_fault}, 32'h1);
    chk("range_cause", {30'd0, fault_cause}, 32'h2);
    chk("range_valid", {31'd0, if_id_valid}, 32'h0);
    chk("range_count", fetch_count, 32'd1024);
    stall = 1'b0;

    // Aligned out-of-range redirect accepted, faults one edge later
    rst = 1'b1;
    step();
    chk_reset("rst3");
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h1000;
    step();
    redirect = 1'b0;
    chk("oor_nofault", {31'd0, fetch_fault}, 32'h0);
    chk("oor_romaddr", rom_addr, 32'h400);
    step();
    chk("oor_fault", {31'd0, fetch_fault}, 32'h1);
    chk("oor_cause", {30'd0, fault_cause}, 32'h2);

    // Recovery from halt
    rst = 1'b1;
    step();
    chk_reset("rst4");
    rst = 1'b0;
    step(); chk_ifid("resume", 1'b1, 32'h0, 32'h1111_1111, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
